// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter: FSM encoding,
// requester count and the one-hot helper used for grant vectors.
package shared_reg_arbiter_pkg;

  // Number of requesters contending for the shared register.
  localparam int NREQ = 4;

  // Two-state arbitration FSM.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Convert a requester index into a one-hot requester vector.
  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    logic [NREQ-1:0] vec;
    vec = 4'b0001 << idx;
    return vec;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick4.sv
// Combinational round-robin picker for four requesters. The search starts
// at index 'start' and wraps; the first set request bit found wins.
module rr_pick4
  import shared_reg_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      start,
  output logic            valid,
  output logic [1:0]      idx
);

  logic [NREQ-1:0] rot_s;
  logic [1:0]      off_s;

  // Rotate so that bit 0 of rot_s is the request at the search start.
  assign rot_s = 4'({req, req} >> start);

  // Priority-encode the rotated vector: lowest offset from start wins.
  always_comb begin
    off_s = 2'd0;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
  end

  assign valid = |req;
  assign idx   = start + off_s;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Four-way arbiter for a single shared register. One requester owns the
// register at a time; each cycle spent in GRANT writes the owner's data.
// An owner may hold the register with 'lock' for at most MAXBURST
// consecutive grants, after which ownership rotates round-robin.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAXBURST = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [1:0]           owner,
  output logic [WIDTH-1:0]     reg_q,
  output logic                 busy
);

  // Burst counter must hold values 0..MAXBURST-1; keep at least one bit.
  localparam int BCW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
  localparam logic [BCW-1:0] BCNT_LAST = BCW'(MAXBURST - 1);
  localparam logic [BCW-1:0] BCNT_ONE  = BCW'(1);

  state_t            state_r;
  logic [NREQ-1:0]   gnt_r;
  logic [1:0]        owner_r;
  logic [1:0]        ptr_r;
  logic [BCW-1:0]    bcnt_r;
  logic [WIDTH-1:0]  reg_q_r;
  logic              busy_r;

  logic [NREQ-1:0]   pick_req_s;
  logic [1:0]        pick_start_s;
  logic              pick_valid_s;
  logic [1:0]        pick_idx_s;
  logic              hold_s;
  logic [WIDTH-1:0]  slice_s;

  // Owner keeps the register while it still wants it, holds lock, and has
  // not yet used up its burst allowance.
  assign hold_s = lock[owner_r] & req[owner_r] & (bcnt_r < BCNT_LAST);

  // Feed the single picker: from ptr when idle; when rotating away from
  // the owner, mask its bit and start just after it so a re-request from
  // the outgoing owner waits behind everyone else.
  always_comb begin
    pick_req_s   = req;
    pick_start_s = ptr_r;
    if (state_r == GRANT) begin
      pick_req_s   = req & ~onehot4(owner_r);
      pick_start_s = owner_r + 2'd1;
    end else begin
      pick_req_s   = req;
      pick_start_s = ptr_r;
    end
  end

  rr_pick4 u_pick (
    .req   (pick_req_s),
    .start (pick_start_s),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Select the current owner's data lane.
  always_comb begin
    slice_s = {WIDTH{1'b0}};
    case (owner_r)
      2'd0:    slice_s = wdata[0*WIDTH +: WIDTH];
      2'd1:    slice_s = wdata[1*WIDTH +: WIDTH];
      2'd2:    slice_s = wdata[2*WIDTH +: WIDTH];
      2'd3:    slice_s = wdata[3*WIDTH +: WIDTH];
      default: slice_s = {WIDTH{1'b0}};
    endcase
  end

  // Arbitration FSM with registered grant, owner, busy and shared register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      gnt_r   <= 4'b0000;
      owner_r <= 2'd0;
      ptr_r   <= 2'd0;
      bcnt_r  <= {BCW{1'b0}};
      reg_q_r <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            state_r <= GRANT;
            gnt_r   <= onehot4(pick_idx_s);
            owner_r <= pick_idx_s;
            busy_r  <= 1'b1;
          end else begin
            gnt_r   <= 4'b0000;
            busy_r  <= 1'b0;
          end
        end
        GRANT: begin
          reg_q_r <= slice_s;
          if (hold_s) begin
            bcnt_r <= bcnt_r + BCNT_ONE;
          end else begin
            ptr_r  <= owner_r + 2'd1;
            bcnt_r <= {BCW{1'b0}};
            if (pick_valid_s) begin
              gnt_r   <= onehot4(pick_idx_s);
              owner_r <= pick_idx_s;
            end else begin
              state_r <= IDLE;
              gnt_r   <= 4'b0000;
              busy_r  <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= 4'b0000;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = gnt_r;
  assign owner = owner_r;
  assign reg_q = reg_q_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus a
// randomized run compared against a behavioural round-robin model.
module tb_shared_reg_arbiter;

  localparam int W  = 32;
  localparam int MB = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [3:0]     req = 4'b0000;
  logic [3:0]     lock = 4'b0000;
  logic [4*W-1:0] wdata = '0;
  logic [3:0]     gnt;
  logic [1:0]     owner;
  logic [W-1:0]   reg_q;
  logic           busy;

  int checks = 0;
  int failures = 0;

  // Behavioural model: who owns the register, if anyone, and the
  // bookkeeping the rules need.
  bit          m_busy;
  int          m_owner;
  int          m_ptr;
  int          m_bcnt;
  logic [W-1:0] m_reg;

  always #5 clk = ~clk;

  shared_reg_arbiter #(.WIDTH(W), .MAXBURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .gnt   (gnt),
    .owner (owner),
    .reg_q (reg_q),
    .busy  (busy)
  );

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_bcnt  = 0;
    m_reg   = '0;
  endtask

  // Apply one clock edge's worth of the arbitration rules to the model.
  task automatic model_step();
    int  w;
    int  cand;
    bit  found;
    found = 1'b0;
    w = 0;
    if (!m_busy) begin
      for (int i = 0; i < 4; i++) begin
        cand = (m_ptr + i) % 4;
        if (!found && req[cand]) begin
          found = 1'b1;
          w = cand;
        end
      end
      if (found) begin
        m_busy  = 1'b1;
        m_owner = w;
      end
    end else begin
      m_reg = wdata[m_owner*W +: W];
      if (lock[m_owner] && req[m_owner] && (m_bcnt < MB - 1)) begin
        m_bcnt = m_bcnt + 1;
      end else begin
        for (int i = 1; i < 4; i++) begin
          cand = (m_owner + i) % 4;
          if (!found && req[cand]) begin
            found = 1'b1;
            w = cand;
          end
        end
        m_ptr  = (m_owner + 1) % 4;
        m_bcnt = 0;
        if (found) m_owner = w;
        else m_busy = 1'b0;
      end
    end
  endtask

  // One clock: advance the model on the current inputs, then sample after the edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    lock  = 4'b0000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b0000;
    lock  = 4'b0000;
    wdata = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_hold_gnt got=%b exp=%b", gnt, 4'b0000); end
    checks++; if (reg_q !== 32'h0) begin failures++; $display("FAIL reset_hold_reg got=%h exp=%h", reg_q, 32'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_hold_busy got=%b exp=%b", busy, 1'b0); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_hold_owner got=%0d exp=%0d", owner, 0); end
    model_reset();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_idle_gnt cyc=%0d got=%b exp=%b", i, gnt, 4'b0000); end
      checks++; if (reg_q !== 32'h0) begin failures++; $display("FAIL reset_idle_reg cyc=%0d got=%h exp=%h", i, reg_q, 32'h0); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy cyc=%0d got=%b exp=%b", i, busy, 1'b0); end
    end
  endtask

  task automatic test_single_write();
    do_reset();
    wdata[31:0] = 32'hA5A5A5A5;
    req = 4'b0001;
    cyc();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=%b", gnt, 4'b0001); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=%b", busy, 1'b1); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL single_owner got=%0d exp=%0d", owner, 0); end
    checks++; if (reg_q !== 32'h0) begin failures++; $display("FAIL single_reg_early got=%h exp=%h", reg_q, 32'h0); end
    cyc();
    req = 4'b0000;
    checks++; if (reg_q !== 32'hA5A5A5A5) begin failures++; $display("FAIL single_reg got=%h exp=%h", reg_q, 32'hA5A5A5A5); end
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_idle_gnt got=%b exp=%b", gnt, 4'b0000); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=%b", busy, 1'b0); end
    wdata[31:0] = 32'h12345678;
    cyc();
    checks++; if (reg_q !== 32'hA5A5A5A5) begin failures++; $display("FAIL idle_no_write got=%h exp=%h", reg_q, 32'hA5A5A5A5); end
  endtask

  task automatic test_contention();
    logic [W-1:0] dv [4];
    logic [3:0]   eg;
    dv[0] = 32'h1000_0A00;
    dv[1] = 32'h2000_0B11;
    dv[2] = 32'h3000_0C22;
    dv[3] = 32'h4000_0D33;
    do_reset();
    wdata = {dv[3], dv[2], dv[1], dv[0]};
    req = 4'b1111;
    cyc();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL contend_first got=%b exp=%b", gnt, 4'b0001); end
    for (int k = 1; k < 4; k++) begin
      cyc();
      req[k-1] = 1'b0;
      eg = 4'b0001 << k;
      checks++; if (gnt !== eg) begin failures++; $display("FAIL contend_order k=%0d got=%b exp=%b", k, gnt, eg); end
      checks++; if (reg_q !== dv[k-1]) begin failures++; $display("FAIL contend_reg k=%0d got=%h exp=%h", k, reg_q, dv[k-1]); end
    end
    cyc();
    req[3] = 1'b0;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL contend_end_gnt got=%b exp=%b", gnt, 4'b0000); end
    checks++; if (reg_q !== dv[3]) begin failures++; $display("FAIL contend_end_reg got=%h exp=%h", reg_q, dv[3]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL contend_end_busy got=%b exp=%b", busy, 1'b0); end
  endtask

  task automatic test_burst_cap();
    do_reset();
    wdata = {$urandom, $urandom, $urandom, $urandom};
    req  = 4'b0011;
    lock = 4'b0001;
    cyc();
    for (int i = 0; i < MB; i++) begin
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL burst_hold i=%0d got=%b exp=%b", i, gnt, 4'b0001); end
      cyc();
    end
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL burst_rotate got=%b exp=%b", gnt, 4'b0010); end
    req  = 4'b0010;
    lock = 4'b0000;
    cyc();
    req = 4'b0000;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL burst_end got=%b exp=%b", gnt, 4'b0000); end
  endtask

  task automatic test_fairness();
    do_reset();
    req = 4'b0101;
    cyc();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL fair_first got=%b exp=%b", gnt, 4'b0001); end
    cyc();
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL fair_req2_first got=%b exp=%b", gnt, 4'b0100); end
    cyc();
    req[2] = 1'b0;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL fair_req0_second got=%b exp=%b", gnt, 4'b0001); end
    cyc();
    req = 4'b0000;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL fair_end got=%b exp=%b", gnt, 4'b0000); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    wdata[31:0]  = 32'hCAFE0001;
    wdata[95:64] = 32'hBEEF0002;
    req = 4'b0001;
    cyc();
    req = 4'b0101;
    cyc();
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL midrst_pre_gnt got=%b exp=%b", gnt, 4'b0100); end
    checks++; if (reg_q !== 32'hCAFE0001) begin failures++; $display("FAIL midrst_pre_reg got=%h exp=%h", reg_q, 32'hCAFE0001); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL midrst_async_gnt got=%b exp=%b", gnt, 4'b0000); end
    checks++; if (reg_q !== 32'h0) begin failures++; $display("FAIL midrst_async_reg got=%h exp=%h", reg_q, 32'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_async_busy got=%b exp=%b", busy, 1'b0); end
    @(posedge clk);
    #1;
    checks++; if (reg_q !== 32'h0) begin failures++; $display("FAIL midrst_no_write got=%h exp=%h", reg_q, 32'h0); end
    model_reset();
    reset = 1'b0;
    cyc();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL midrst_restart got=%b exp=%b", gnt, 4'b0001); end
    req = 4'b0100;
    cyc();
    cyc();
    req = 4'b0000;
    cyc();
  endtask

  task automatic test_random();
    logic [3:0] eg;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      end
      if ((n / 60) % 2 == 0) lock = 4'b1111;
      else lock = 4'($urandom);
      wdata = {$urandom, $urandom, $urandom, $urandom};
      cyc();
      eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
      checks++; if (gnt !== eg) begin failures++; $display("FAIL rand_gnt n=%0d got=%b exp=%b", n, gnt, eg); end
      checks++; if (busy !== m_busy) begin failures++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, busy, m_busy); end
      checks++; if (reg_q !== m_reg) begin failures++; $display("FAIL rand_reg n=%0d got=%h exp=%h", n, reg_q, m_reg); end
      checks++; if ($onehot0(gnt) !== 1'b1) begin failures++; $display("FAIL rand_onehot n=%0d got=%b exp=onehot0", n, gnt); end
      if (m_busy) begin
        checks++; if (owner !== 2'(m_owner)) begin failures++; $display("FAIL rand_owner n=%0d got=%0d exp=%0d", n, owner, m_owner); end
      end
    end
    req  = 4'b0000;
    lock = 4'b0000;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_burst_cap();
    test_fairness();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends even if the sequence stalls.
  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
